mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, 1 = round-robin arbitration between ports, 0 = fixed priority to port 0.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 req0 / req1  input  1  request from port 0 / 1; held high until the matching ack.
REQ-006 rw0 / rw1  input  1  0 = write, 1 = read; stable while req is high.
REQ-007 addr0 / addr1  input  8  memory address; stable while req is high.
REQ-008 wdata0 / wdata1  input  8  write data; stable while req is high.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse for port 0 / 1.
REQ-010 rdata0 / rdata1  output  8  read data; valid from the ack cycle, held until the next read ack on the same port.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 mem_rw  output  1  to memory rw; 0 = write, 1 = read.
REQ-013 mem_addr  output  8  to memory addr.
REQ-014 mem_datain  output  8  to memory datain.
REQ-015 mem_dataout  input  8  from memory dataout; updated at the edge after a read is sampled.

Function
REQ-016 States: IDLE, ISSUE, RDATA, ACK; all outputs are registered.
REQ-017 IDLE: if no req is high, stay in IDLE; otherwise grant one port, load its rw/addr/wdata into holding registers (mem_addr, mem_datain, op), and go to ISSUE.
REQ-018 Arbitration, FAIR=1: a lone requester wins; if both request, the port not granted last wins; last-grant pointer updates on every grant.
REQ-019 Arbitration, FAIR=0: port 0 wins whenever req0 is high.
REQ-020 ISSUE: mem_rw = op; memory performs the access at the edge ending ISSUE; next state is RDATA for a read, ACK for a write.
REQ-021 RDATA: mem_rw=1 and mem_addr still holds the read address; at the edge ending RDATA, capture mem_dataout into the granted port's rdata; go to ACK.
REQ-022 ACK: ack of the granted port = 1 for exactly this cycle; the other ack = 0; go to IDLE.
REQ-023 mem_rw = 0 only during ISSUE of a write; in every other state mem_rw = 1.
REQ-024 mem_addr and mem_datain change only on a grant.
REQ-025 Because of REQ-023 and REQ-024, idle cycles re-read the last address and are harmless.
REQ-026 Latency, first IDLE cycle with req high = cycle 0: a write acks in cycle 2, a read acks in cycle 3.
REQ-027 Throughput: back-to-back writes every 3 cycles; back-to-back reads every 4 cycles.
REQ-028 After an ack, the requester drops or updates req at that edge; the IDLE cycle that follows samples the new value.
REQ-029 Requests arriving while busy are not lost; they are evaluated in the next IDLE cycle.
REQ-030 Both ports requesting the same address: serviced in arbitration order; a read after a write returns the new data.
REQ-031 Never more than one ack high in any cycle; never an ack without a prior grant.

Reset
REQ-032 reset_n low at an edge forces: state IDLE, ack0/ack1 = 0, rdata0/rdata1 = 0, busy = 0, mem_rw = 1, mem_addr = 0, mem_datain = 0, last-grant pointer = port 1 (so port 0 wins the first tie).
REQ-033 Reset mid-operation aborts the operation with no ack.
REQ-034 A write whose ISSUE cycle ends on the reset edge is still performed by the memory.
REQ-035 The arbiter neither tracks nor undoes memory contents across reset.

Verification
REQ-036 Single write then read, port 0: write addr 0x10 data 0xA5 -> ack0 in cycle 2; read 0x10 -> ack0 in cycle 3 with rdata0 = 0xA5; ack1 never asserted.
REQ-037 Tie, FAIR=1: req0 and req1 held continuously for writes -> grants alternate 0,1,0,1 starting with port 0; an ack every 3 cycles.
REQ-038 Tie, FAIR=0: both held continuously -> port 0 wins every grant; port 1 acked only after req0 drops.
REQ-039 Cross-port coherence: port 1 writes 0x3C to 0xFF, then port 0 reads 0xFF -> rdata0 = 0x3C; rdata1 unchanged.
REQ-040 Reset during RDATA of a read: no ack; outputs at reset values next cycle; a fresh read completes normally in 3 cycles.
REQ-041 Idle hold: no requests for 20 cycles after a write to 0x22 -> mem_rw = 1, mem_addr = 0x22, busy = 0 throughout; memory contents unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single synchronous memory.
// Grants one request per IDLE cycle and sequences it through ISSUE/RDATA/ACK.
module mem_arbiter #(
    parameter int FAIR = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       busy,
    output logic       mem_rw,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_datain,
    input  logic [7:0] mem_dataout
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDATA,
        ACK
    } state_t;

    state_t state;
    logic   op;      // 1 = read of the granted transfer
    logic   gnt;     // port currently being serviced
    logic   last;    // port granted most recently
    logic   pick;

    always_comb begin
        pick = 1'b0;
        if (req0 && req1)
            pick = (FAIR != 0) ? ~last : 1'b0;
        else
            pick = req1 & ~req0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            busy       <= 1'b0;
            mem_rw     <= 1'b1;
            mem_addr   <= '0;
            mem_datain <= '0;
            last       <= 1'b1;
            op         <= 1'b1;
            gnt        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt        <= pick;
                        last       <= pick;
                        op         <= pick ? rw1 : rw0;
                        mem_rw     <= pick ? rw1 : rw0;
                        mem_addr   <= pick ? addr1 : addr0;
                        mem_datain <= pick ? wdata1 : wdata0;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Memory performs the access on this edge; idle reads afterwards are harmless.
                    mem_rw <= 1'b1;
                    if (op) begin
                        state <= RDATA;
                    end else begin
                        ack0  <= ~gnt;
                        ack1  <= gnt;
                        state <= ACK;
                    end
                end
                RDATA: begin
                    if (gnt)
                        rdata1 <= mem_dataout;
                    else
                        rdata0 <= mem_dataout;
                    ack0  <= ~gnt;
                    ack1  <= gnt;
                    state <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
